// File: rtl/tb_run_controller.sv
// Run controller for the core testbench: sequences the core reset, counts run cycles and
// reduces per-hart pass/fail/exit/hang observations to one sticky, registered verdict.
module tb_run_controller #(
  parameter int unsigned NUM_HARTS         = 1,
  parameter int unsigned PC_WIDTH          = 32,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned RESET_WAIT_CYCLES = 4,
  parameter int unsigned HANG_CYCLES       = 1024,
  parameter int unsigned HOLD_ON_DONE      = 1,
  localparam int unsigned HartW            = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CNT_WIDTH-1:0]          max_cycles_i,
  input  logic [NUM_HARTS-1:0]          tests_passed_i,
  input  logic [NUM_HARTS-1:0]          tests_failed_i,
  input  logic [NUM_HARTS-1:0]          exit_valid_i,
  input  logic [32*NUM_HARTS-1:0]       exit_value_i,
  input  logic [PC_WIDTH*NUM_HARTS-1:0] pc_i,
  input  logic [NUM_HARTS-1:0]          pc_valid_i,
  output logic                          core_rst_no,
  output logic                          done_o,
  output logic [2:0]                    status_o,
  output logic [HartW-1:0]              hart_o,
  output logic [31:0]                   exit_code_o,
  output logic [CNT_WIDTH-1:0]          cycle_cnt_o
);

  localparam int unsigned WaitW       = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RESET_WAIT_CYCLES - 1);
  localparam int unsigned HangW       = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
  localparam int unsigned HangLastInt = (HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0;
  localparam logic [HangW-1:0] HangLast = HangW'(HangLastInt);

  localparam logic [2:0] StatRunning = 3'd0;
  localparam logic [2:0] StatPass    = 3'd1;
  localparam logic [2:0] StatFail    = 3'd2;
  localparam logic [2:0] StatExitOk  = 3'd3;
  localparam logic [2:0] StatExitErr = 3'd4;
  localparam logic [2:0] StatTimeout = 3'd5;
  localparam logic [2:0] StatHang    = 3'd6;

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic                   core_rst_q, core_rst_d;
  logic                   done_q, done_d;
  logic [2:0]             status_q, status_d;
  logic [HartW-1:0]       hart_q, hart_d;
  logic [31:0]            exit_code_q, exit_code_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_HARTS-1:0]   pass_q, pass_d;
  logic [NUM_HARTS-1:0]   exok_q, exok_d;
  logic [NUM_HARTS-1:0]   loaded_q, loaded_d;
  logic [PC_WIDTH-1:0]    pc_q [NUM_HARTS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_HARTS];
  logic [HangW-1:0]       hang_q [NUM_HARTS];
  logic [HangW-1:0]       hang_d [NUM_HARTS];

  logic [NUM_HARTS-1:0]   exit_zero_v, exit_err_v, pc_same_v, hang_hit_v;
  logic                   timeout;
  logic                   evt;
  logic [2:0]             evt_status;
  logic [HartW-1:0]       evt_hart;
  logic [31:0]            evt_code;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      exit_zero_v[h] = exit_valid_i[h] && (exit_value_i[32*h +: 32] == 32'd0);
      exit_err_v[h]  = exit_valid_i[h] && (exit_value_i[32*h +: 32] != 32'd0);
      pc_same_v[h]   = loaded_q[h] && (pc_i[PC_WIDTH*h +: PC_WIDTH] == pc_q[h]);
      hang_hit_v[h]  = (HANG_CYCLES != 0) && pc_valid_i[h] && pc_same_v[h] &&
                       (hang_q[h] == HangLast);
    end
    timeout = (max_cycles_i != '0) && (cnt_q >= max_cycles_i - CNT_WIDTH'(1));
  end

  // Event priority; the downward loops leave the lowest matching hart index in evt_hart.
  always_comb begin
    evt        = 1'b0;
    evt_status = StatRunning;
    evt_hart   = '0;
    evt_code   = '0;
    if (|tests_failed_i) begin
      evt        = 1'b1;
      evt_status = StatFail;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
        if (tests_failed_i[h]) evt_hart = HartW'(h);
      end
    end else if (|exit_err_v) begin
      evt        = 1'b1;
      evt_status = StatExitErr;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
        if (exit_err_v[h]) begin
          evt_hart = HartW'(h);
          evt_code = exit_value_i[32*h +: 32];
        end
      end
    end else if (timeout) begin
      evt        = 1'b1;
      evt_status = StatTimeout;
    end else if (|hang_hit_v) begin
      evt        = 1'b1;
      evt_status = StatHang;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
        if (hang_hit_v[h]) evt_hart = HartW'(h);
      end
    end else if (&(exok_q | exit_zero_v)) begin
      evt        = 1'b1;
      evt_status = StatExitOk;
    end else if (&(pass_q | tests_passed_i)) begin
      evt        = 1'b1;
      evt_status = StatPass;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    core_rst_d  = core_rst_q;
    done_d      = done_q;
    status_d    = status_q;
    hart_d      = hart_q;
    exit_code_d = exit_code_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    exok_d      = exok_q;
    loaded_d    = loaded_q;
    pc_d        = pc_q;
    hang_d      = hang_q;

    case (state_q)
      StHold: begin
        if (wait_q == WaitLast) begin
          state_d    = StRun;
          core_rst_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRun: begin
        pass_d = pass_q | tests_passed_i;
        exok_d = exok_q | exit_zero_v;
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (pc_valid_i[h]) begin
            if (pc_same_v[h]) begin
              if (hang_q[h] != HangLast) hang_d[h] = hang_q[h] + HangW'(1);
            end else begin
              hang_d[h]   = '0;
              pc_d[h]     = pc_i[PC_WIDTH*h +: PC_WIDTH];
              loaded_d[h] = 1'b1;
            end
          end
        end
        if (evt) begin
          state_d     = StDone;
          done_d      = 1'b1;
          status_d    = evt_status;
          hart_d      = evt_hart;
          exit_code_d = evt_code;
          core_rst_d  = (HOLD_ON_DONE == 0);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StDone: ;
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StHold;
      wait_q      <= '0;
      core_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= StatRunning;
      hart_q      <= '0;
      exit_code_q <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      exok_q      <= '0;
      loaded_q    <= '0;
      pc_q        <= '{default: '0};
      hang_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      status_q    <= status_d;
      hart_q      <= hart_d;
      exit_code_q <= exit_code_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      exok_q      <= exok_d;
      loaded_q    <= loaded_d;
      pc_q        <= pc_d;
      hang_q      <= hang_d;
    end
  end

  assign core_rst_no = core_rst_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign hart_o      = hart_q;
  assign exit_code_o = exit_code_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_tb_run_controller.sv
// Directed bench for tb_run_controller: two harts, 4-cycle reset wait, 16-cycle hang window.
module tb_tb_run_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] max_cycles_i;
  logic [1:0]  tests_passed_i, tests_failed_i, exit_valid_i, pc_valid_i;
  logic [63:0] exit_value_i, pc_i;
  logic        core_rst_no, done_o;
  logic [2:0]  status_o;
  logic [0:0]  hart_o;
  logic [31:0] exit_code_o, cycle_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  tb_run_controller #(
    .NUM_HARTS        (2),
    .PC_WIDTH         (32),
    .CNT_WIDTH        (32),
    .RESET_WAIT_CYCLES(4),
    .HANG_CYCLES      (16),
    .HOLD_ON_DONE     (1)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .max_cycles_i  (max_cycles_i),
    .tests_passed_i(tests_passed_i),
    .tests_failed_i(tests_failed_i),
    .exit_valid_i  (exit_valid_i),
    .exit_value_i  (exit_value_i),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .core_rst_no   (core_rst_no),
    .done_o        (done_o),
    .status_o      (status_o),
    .hart_o        (hart_o),
    .exit_code_o   (exit_code_o),
    .cycle_cnt_o   (cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic idle_inputs();
    tests_passed_i = '0;
    tests_failed_i = '0;
    exit_valid_i   = '0;
    exit_value_i   = '0;
    pc_i           = '0;
    pc_valid_i     = '0;
  endtask

  // After this returns, the bench sits in RUN cycle 0.
  task automatic start_run();
    idle_inputs();
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    max_cycles_i = '0;
    rst_i        = 1'b1;
    tick(2);

    // Reset values and HOLD sequencing
    rst_i = 1'b0;
    check_eq("rst_core_rst", {31'd0, core_rst_no}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_status", {29'd0, status_o}, 32'd0);
    check_eq("rst_hart", {31'd0, hart_o}, 32'd0);
    check_eq("rst_exit_code", exit_code_o, 32'd0);
    check_eq("rst_cycle_cnt", cycle_cnt_o, 32'd0);
    tick(3);
    check_eq("hold_cycle3_core_rst", {31'd0, core_rst_no}, 32'd0);
    tick(1);
    check_eq("run0_core_rst", {31'd0, core_rst_no}, 32'd1);
    check_eq("run0_cycle_cnt", cycle_cnt_o, 32'd0);
    check_eq("run0_status", {29'd0, status_o}, 32'd0);
    tick(3);
    check_eq("run3_cycle_cnt", cycle_cnt_o, 32'd3);

    // Staggered pass: hart0 at RUN cycle 10, hart1 at RUN cycle 20
    start_run();
    tick(10);
    tests_passed_i = 2'b01;
    tick(1);
    tests_passed_i = 2'b00;
    tick(9);
    check_eq("partial_pass_done", {31'd0, done_o}, 32'd0);
    tests_passed_i = 2'b10;
    tick(1);
    tests_passed_i = 2'b00;
    check_eq("pass_done", {31'd0, done_o}, 32'd1);
    check_eq("pass_status", {29'd0, status_o}, 32'd1);
    check_eq("pass_hart", {31'd0, hart_o}, 32'd0);
    check_eq("pass_core_rst", {31'd0, core_rst_no}, 32'd0);
    check_eq("pass_cycle_cnt", cycle_cnt_o, 32'd20);
    tests_failed_i = 2'b11;
    tick(5);
    tests_failed_i = 2'b00;
    check_eq("done_frozen_status", {29'd0, status_o}, 32'd1);
    check_eq("done_frozen_cnt", cycle_cnt_o, 32'd20);

    // FAIL outranks EXIT_ERR in the same cycle
    start_run();
    tick(2);
    tests_failed_i = 2'b10;
    exit_valid_i   = 2'b01;
    exit_value_i   = {32'd0, 32'd5};
    tick(1);
    idle_inputs();
    check_eq("fail_done", {31'd0, done_o}, 32'd1);
    check_eq("fail_status", {29'd0, status_o}, 32'd2);
    check_eq("fail_hart", {31'd0, hart_o}, 32'd1);
    check_eq("fail_exit_code", exit_code_o, 32'd0);

    // Partial pass followed by a fail on the passed hart
    start_run();
    tests_passed_i = 2'b01;
    tick(1);
    tests_passed_i = 2'b00;
    tick(3);
    check_eq("partial_run_done", {31'd0, done_o}, 32'd0);
    tests_failed_i = 2'b01;
    tick(1);
    tests_failed_i = 2'b00;
    check_eq("partial_fail_status", {29'd0, status_o}, 32'd2);
    check_eq("partial_fail_hart", {31'd0, hart_o}, 32'd0);

    // Both harts exit with zero on different cycles
    start_run();
    exit_valid_i = 2'b01;
    tick(1);
    exit_valid_i = 2'b00;
    tick(2);
    check_eq("exok_partial_done", {31'd0, done_o}, 32'd0);
    exit_valid_i = 2'b10;
    tick(1);
    exit_valid_i = 2'b00;
    check_eq("exok_status", {29'd0, status_o}, 32'd3);
    check_eq("exok_hart", {31'd0, hart_o}, 32'd0);

    // Watchdog at 100 cycles
    max_cycles_i = 32'd100;
    start_run();
    tick(99);
    check_eq("timeout_early_done", {31'd0, done_o}, 32'd0);
    tick(1);
    check_eq("timeout_done", {31'd0, done_o}, 32'd1);
    check_eq("timeout_status", {29'd0, status_o}, 32'd5);
    check_eq("timeout_cycle_cnt", cycle_cnt_o, 32'd99);

    // Watchdog disabled
    max_cycles_i = 32'd0;
    start_run();
    tick(10000);
    check_eq("nowd_done", {31'd0, done_o}, 32'd0);
    check_eq("nowd_cycle_cnt", cycle_cnt_o, 32'd10000);

    // Hang on hart0: PC loads in cycle 0, 16 unchanged cycles follow
    start_run();
    pc_i       = {32'd0, 32'h80};
    pc_valid_i = 2'b01;
    tick(16);
    check_eq("hang0_early_done", {31'd0, done_o}, 32'd0);
    tick(1);
    check_eq("hang0_status", {29'd0, status_o}, 32'd6);
    check_eq("hang0_hart", {31'd0, hart_o}, 32'd0);

    // Hang on hart1 only
    start_run();
    pc_i       = {32'h1234, 32'd0};
    pc_valid_i = 2'b10;
    tick(17);
    check_eq("hang1_status", {29'd0, status_o}, 32'd6);
    check_eq("hang1_hart", {31'd0, hart_o}, 32'd1);

    // Three invalid cycles mid-stall push the verdict out by three
    start_run();
    pc_i       = {32'd0, 32'h80};
    pc_valid_i = 2'b01;
    tick(8);
    pc_valid_i = 2'b00;
    tick(3);
    pc_valid_i = 2'b01;
    tick(8);
    check_eq("hang_gap_early_done", {31'd0, done_o}, 32'd0);
    tick(1);
    check_eq("hang_gap_done", {31'd0, done_o}, 32'd1);
    check_eq("hang_gap_status", {29'd0, status_o}, 32'd6);

    // EXIT_ERR then a one-cycle reset while DONE
    start_run();
    exit_valid_i = 2'b10;
    exit_value_i = {32'hDEAD, 32'd0};
    tick(1);
    idle_inputs();
    check_eq("exerr_status", {29'd0, status_o}, 32'd4);
    check_eq("exerr_hart", {31'd0, hart_o}, 32'd1);
    check_eq("exerr_code", exit_code_o, 32'hDEAD);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check_eq("rerst_done", {31'd0, done_o}, 32'd0);
    check_eq("rerst_status", {29'd0, status_o}, 32'd0);
    check_eq("rerst_hart", {31'd0, hart_o}, 32'd0);
    check_eq("rerst_exit_code", exit_code_o, 32'd0);
    check_eq("rerst_core_rst", {31'd0, core_rst_no}, 32'd0);
    tick(3);
    check_eq("rerst_hold3_core_rst", {31'd0, core_rst_no}, 32'd0);
    tick(1);
    check_eq("rerst_run_core_rst", {31'd0, core_rst_no}, 32'd1);
    check_eq("rerst_run_cnt", cycle_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tb_run_controller.md
Name: tb_run_controller

Overview:
- Synthesizable run controller for the core testbench. Replaces the ad-hoc reset sequencing, max-cycle abort and pass/fail/exit checks with one registered, parametrised block.
- Sequences the DUT reset and counts run cycles.
- Monitors NUM_HARTS harts for pass, fail, exit and hang (PC stuck).
- Reports a single sticky verdict. The bench calls $display/$finish only when done_o is high.

Parameters:
- NUM_HARTS, 1: number of monitored harts/channels (1..8).
- PC_WIDTH, 32: width of each hart PC.
- CNT_WIDTH, 32: width of the cycle counter and of max_cycles_i.
- RESET_WAIT_CYCLES, 4: cycles core_rst_no is held low after rst_i deasserts (>=1).
- HANG_CYCLES, 1024: consecutive valid cycles with an unchanged PC that flag a hang; 0 disables hang detection.
- HOLD_ON_DONE, 1: 1 = drive core_rst_no low again once in DONE; 0 = leave the core running.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- max_cycles_i  in  CNT_WIDTH  cycle limit; 0 disables the watchdog.
- tests_passed_i  in  NUM_HARTS  per-hart pass pulse/level.
- tests_failed_i  in  NUM_HARTS  per-hart fail.
- exit_valid_i  in  NUM_HARTS  per-hart exit strobe.
- exit_value_i  in  32*NUM_HARTS  per-hart exit code; hart h occupies [32h+31:32h].
- pc_i  in  PC_WIDTH*NUM_HARTS  per-hart fetch PC.
- pc_valid_i  in  NUM_HARTS  per-hart PC qualifier.
- core_rst_no  out  1  active-low reset to the DUT wrapper.
- done_o  out  1  verdict valid (sticky).
- status_o  out  3  0 RUNNING, 1 PASS, 2 FAIL, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT, 6 HANG.
- hart_o  out  max(1,$clog2(NUM_HARTS))  hart that caused the verdict (0 for PASS/EXIT_OK/TIMEOUT).
- exit_code_o  out  32  exit value for EXIT_ERR, else 0.
- cycle_cnt_o  out  CNT_WIDTH  run-cycle count.

Behaviour:
- State machine: HOLD -> RUN -> DONE. rst_i forces HOLD from any state, including mid-run.
- Reset values: core_rst_no=0, done_o=0, status_o=0, hart_o=0, exit_code_o=0, cycle_cnt_o=0, all sticky flags and hang counters cleared.
- HOLD:
  - A wait counter counts cycles with rst_i low.
  - core_rst_no rises at the edge ending the RESET_WAIT_CYCLES-th such cycle; the state becomes RUN at the same edge.
  - All hart inputs are ignored in HOLD.
- RUN, cycle counter:
  - cycle_cnt_o increments by 1 every RUN cycle, starting from 0.
  - It saturates at all-ones and does not wrap.
- RUN, per-hart sticky flags:
  - pass_q[h] is set by tests_passed_i[h].
  - exok_q[h] is set by exit_valid_i[h] with exit_value 0.
- RUN, events evaluated combinationally each cycle, in priority order (highest first). The first true event wins; among harts, the lowest index wins:
  1. FAIL: any tests_failed_i.
  2. EXIT_ERR: any exit_valid_i with exit_value != 0; exit_code_o latches that value.
  3. TIMEOUT: max_cycles_i != 0 and cycle_cnt_o >= max_cycles_i - 1.
  4. HANG: HANG_CYCLES != 0 and any hang counter reaches HANG_CYCLES-1 while its PC is still unchanged.
  5. EXIT_OK: every hart has exok_q or a current zero-value exit.
  6. PASS: every hart has pass_q or current tests_passed_i.
- Any winning event moves the state to DONE at the next edge. In the same edge, done_o=1 and status_o, hart_o and exit_code_o are registered. Latency from input to done_o is 1 cycle.
- Hang counter, per hart:
  - pc_valid_i=1 and pc equal to the stored PC: counter +1, saturating.
  - pc_valid_i=1 and pc different: counter=0 and the new PC is stored.
  - pc_valid_i=0: counter holds.
  - The first valid PC after HOLD always loads and does not count.
- DONE:
  - All outputs are frozen; later events are ignored.
  - cycle_cnt_o stops.
  - core_rst_no = !HOLD_ON_DONE.
  - Leaving DONE requires rst_i.
- Partial pass (some harts passed, others still running): stay in RUN. A later fail on any hart yields FAIL.

Test Plan:
- RESET_WAIT_CYCLES=4; deassert rst_i at cycle 0 -> core_rst_no=1 from cycle 4; status_o=0; cycle_cnt_o=0 on the first RUN cycle.
- NUM_HARTS=2; pass hart0 at RUN cycle 10 and hart1 at RUN cycle 20 -> done_o=1 at 21, status=1, hart_o=0, core_rst_no=0.
- Same cycle: tests_failed_i=2'b10 and exit_valid_i=2'b01 with value 5 -> status=2 (FAIL), hart_o=1, exit_code_o=0.
- max_cycles_i=100, no events -> done_o rises on RUN cycle 100, status=5, cycle_cnt_o=99. Repeat with max_cycles_i=0 for 10000 cycles -> no done.
- HANG_CYCLES=16; PC held at 0x80 with pc_valid_i=1 -> status=6, hart_o=0. Toggling pc_valid_i low mid-stall delays the verdict by the number of invalid cycles.
- Assert rst_i for 1 cycle while in DONE with EXIT_ERR (code 0xDEAD) -> all outputs return to reset values; the HOLD sequence repeats.
